// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared sizes and FSM state encoding for the main memory responder
package main_mem_pkg;
  localparam int LINE_WORDS = 16;
  localparam int LINE_BITS = 512;
  localparam int REQ_ADDR_W = 18;
  localparam int MEM_ADDR_W = 22;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, WB, FILL, DELIVER} state_t;
endpackage

// File: rtl/line_fill_engine.sv
// line_fill_engine: issues 16 word reads for one line and assembles the returned words
module line_fill_engine
  import main_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REQ_ADDR_W-1:0] base_addr,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic                  rd_en,
  output logic [MEM_ADDR_W-1:0] rd_addr,
  output logic                  done,
  output logic [LINE_BITS-1:0]  line
);
  logic                        busy;
  logic [4:0]                  k;
  logic [REQ_ADDR_W-1:0]       base;
  logic [LINE_BITS-WORD_W-1:0] words;
  // read data lags the address by one cycle, so word k-1 lands while k is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      k     <= '0;
      base  <= '0;
      words <= '0;
    end else if (start) begin
      busy <= 1'b1;
      k    <= '0;
      base <= base_addr;
    end else if (busy) begin
      k <= k[4] ? 5'd0 : k + 5'd1;
      busy <= !k[4];
      if (k != 5'd0 && !k[4]) words[{k - 5'd1, 5'd0} +: WORD_W] <= mem_rdata;
    end
  end
  assign rd_en   = busy && !k[4];
  assign rd_addr = {base, k[3:0]};
  assign done    = busy && k[4];
  // the last word is still on the bus when done is high
  assign line    = {mem_rdata, words};
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: arbitrates write-backs and prog/data line fills onto one word memory
module main_mem_responder
  import main_mem_pkg::*;
(
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  is_req_prog,
  input  logic                  is_req_data,
  input  logic [REQ_ADDR_W-1:0] req_addr_prog,
  input  logic [REQ_ADDR_W-1:0] req_addr_data,
  input  logic                  wb_fifo_empty,
  input  logic [31:0]           wb_addr,
  input  logic [31:0]           wb_data,
  output logic                  wb_pop,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [LINE_BITS-1:0]  prog_line_data,
  output logic [LINE_BITS-1:0]  data_line_data,
  output logic [7:0]            prog_line_addr,
  output logic [7:0]            data_line_addr,
  output logic                  prog_line_valid,
  output logic                  data_line_valid
);
  state_t                state;
  logic                  src_data, served_prog, served_data;
  logic [7:0]            fill_tag;
  logic                  elig_prog, elig_data, start, wb_go, rd_en, done;
  logic [REQ_ADDR_W-1:0] base_addr;
  logic [MEM_ADDR_W-1:0] rd_addr;
  logic [LINE_BITS-1:0]  eng_line;
  logic                  wb_addr_unused;
  assign wb_addr_unused = ^{wb_addr[31:24], wb_addr[1:0]};
  always_comb begin
    elig_prog = is_req_prog && !served_prog;
    elig_data = is_req_data && !served_data;
    start     = state == IDLE && wb_fifo_empty && (elig_data || elig_prog);
    base_addr = elig_data ? req_addr_data : req_addr_prog;
    wb_go     = state == WB && !wb_fifo_empty;
    wb_pop    = wb_go;
    mem_en    = wb_go || rd_en;
    mem_we    = wb_go;
    mem_addr  = wb_go ? wb_addr[23:2] : rd_addr;
    mem_wdata = wb_go ? wb_data : '0;
  end
  line_fill_engine u_engine (
    .clk       (main_clk),
    .rst       (reset),
    .start     (start),
    .base_addr (base_addr),
    .mem_rdata (mem_rdata),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .done      (done),
    .line      (eng_line)
  );
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      src_data        <= 1'b0;
      fill_tag        <= '0;
      served_prog     <= 1'b0;
      served_data     <= 1'b0;
      prog_line_data  <= '0;
      data_line_data  <= '0;
      prog_line_addr  <= '0;
      data_line_addr  <= '0;
      prog_line_valid <= 1'b0;
      data_line_valid <= 1'b0;
    end else begin
      served_prog     <= is_req_prog && (served_prog || (state == DELIVER && !src_data));
      served_data     <= is_req_data && (served_data || (state == DELIVER && src_data));
      prog_line_valid <= 1'b0;
      data_line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!wb_fifo_empty) state <= WB;
          else if (start) begin
            state    <= FILL;
            src_data <= elig_data;
            fill_tag <= base_addr[7:0];
          end
        end
        WB: state <= IDLE;
        FILL: begin
          if (done) begin
            state <= DELIVER;
            if (src_data) begin
              data_line_data  <= eng_line;
              data_line_addr  <= fill_tag;
              data_line_valid <= 1'b1;
            end else begin
              prog_line_data  <= eng_line;
              prog_line_addr  <= fill_tag;
              prog_line_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed checks of fills, write-back ordering, arbitration and reset
module tb_main_mem_responder;
  logic         main_clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_req_prog = 1'b0, is_req_data = 1'b0;
  logic [17:0]  req_addr_prog = '0, req_addr_data = '0;
  logic         wb_fifo_empty, wb_pop;
  logic [31:0]  wb_addr, wb_data;
  logic         mem_en, mem_we;
  logic [21:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic [511:0] prog_line_data, data_line_data;
  logic [7:0]   prog_line_addr, data_line_addr;
  logic         prog_line_valid, data_line_valid;

  main_mem_responder dut (
    .main_clk(main_clk), .reset(reset),
    .is_req_prog(is_req_prog), .is_req_data(is_req_data),
    .req_addr_prog(req_addr_prog), .req_addr_data(req_addr_data),
    .wb_fifo_empty(wb_fifo_empty), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pop(wb_pop),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .prog_line_data(prog_line_data), .data_line_data(data_line_data),
    .prog_line_addr(prog_line_addr), .data_line_addr(data_line_addr),
    .prog_line_valid(prog_line_valid), .data_line_valid(data_line_valid)
  );

  always #5 main_clk = ~main_clk;

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  // word memory: word n initially holds n, read data one cycle after the request
  logic [31:0] mem [0:4095];
  bit mem_init = 1'b0;
  always @(posedge main_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= i;
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr[11:0]];
  end

  // first-word-fall-through write-back FIFO
  logic [31:0] fa [0:3];
  logic [31:0] fd [0:3];
  int fhead = 0, ftail = 0;
  assign wb_fifo_empty = fhead == ftail;
  assign wb_addr = fa[fhead % 4];
  assign wb_data = fd[fhead % 4];
  always @(posedge main_clk) if (wb_pop) fhead <= fhead + 1;

  int pv_cnt = 0, dv_cnt = 0, pv_cyc = 0, dv_cyc = 0, pop_cnt = 0, pop_empty = 0;
  int pop_t[$];
  always @(negedge main_clk) begin
    if (prog_line_valid) begin pv_cnt++; pv_cyc = cyc; end
    if (data_line_valid) begin dv_cnt++; dv_cyc = cyc; end
    if (wb_pop) begin
      pop_cnt++;
      pop_t.push_back(cyc);
      if (wb_fifo_empty) pop_empty++;
    end
  end

  int vec = 0, errs = 0;

  task automatic tick();
    @(negedge main_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    fa[ftail % 4] = a;
    fd[ftail % 4] = d;
    ftail = ftail + 1;
  endtask

  task automatic wait_valid(input bit for_data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (for_data ? data_line_valid : prog_line_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    is_req_data = 1'b1;
    req_addr_data = 18'h00001;
    repeat (3) tick();
    vec++; if ({prog_line_valid, data_line_valid} !== 2'b00) begin errs++; $display("FAIL reset_valid: got %b want 00", {prog_line_valid, data_line_valid}); end
    vec++; if ({mem_en, mem_we, wb_pop} !== 3'b000) begin errs++; $display("FAIL reset_mem: got %b want 000", {mem_en, mem_we, wb_pop}); end
    vec++; if (prog_line_data !== '0 || data_line_data !== '0) begin errs++; $display("FAIL reset_line_data: got nonzero want 0"); end
    vec++; if ({prog_line_addr, data_line_addr} !== 16'h0) begin errs++; $display("FAIL reset_line_addr: got %h want 0000", {prog_line_addr, data_line_addr}); end
    is_req_data = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_fill();
    int t0;
    bit ok;
    logic [511:0] exp;
    for (int k = 0; k < 16; k++) exp[32*k +: 32] = 48 + k;
    t0 = cyc;
    is_req_prog = 1'b1;
    req_addr_prog = 18'h00003;
    repeat (4) tick();
    req_addr_prog = 18'h00005;
    wait_valid(1'b0, ok);
    vec++; if (!ok || pv_cyc - t0 != 18) begin errs++; $display("FAIL single_latency: got %0d want 18 (seen=%0d)", pv_cyc - t0, ok); end
    vec++; if (prog_line_addr !== 8'h03) begin errs++; $display("FAIL single_addr: got %h want 03", prog_line_addr); end
    vec++; if (prog_line_data !== exp) begin errs++; $display("FAIL single_data: got w0=%h w15=%h want 00000030 0000003f", prog_line_data[31:0], prog_line_data[511:480]); end
    vec++; if (dv_cnt != 0 || data_line_data !== '0 || data_line_addr !== 8'h00) begin errs++; $display("FAIL single_other_src: got dv_cnt=%0d addr=%h want 0 00", dv_cnt, data_line_addr); end
    repeat (25) tick();
    vec++; if (pv_cnt != 1) begin errs++; $display("FAIL single_no_repeat: got %0d want 1", pv_cnt); end
    vec++; if (prog_line_addr !== 8'h03 || prog_line_data[63:32] !== 32'd49) begin errs++; $display("FAIL single_hold: got %h %h want 03 00000031", prog_line_addr, prog_line_data[63:32]); end
    is_req_prog = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_wb_order();
    int t0, p0, d0;
    bit ok;
    p0 = pop_cnt;
    d0 = dv_cnt;
    t0 = cyc;
    push(32'h0000_00C0, 32'hDEADBEEF);
    is_req_data = 1'b1;
    req_addr_data = 18'h00003;
    wait_valid(1'b1, ok);
    vec++; if (!ok || dv_cyc - t0 != 20) begin errs++; $display("FAIL wb_latency: got %0d want 20 (seen=%0d)", dv_cyc - t0, ok); end
    vec++; if (pop_cnt - p0 != 1 || pop_t[pop_t.size()-1] != t0 + 1) begin errs++; $display("FAIL wb_pop: got %0d pops want 1 at cycle %0d", pop_cnt - p0, t0 + 1); end
    vec++; if (data_line_data[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL wb_word0: got %h want deadbeef", data_line_data[31:0]); end
    vec++; if (data_line_data[63:32] !== 32'd49 || data_line_addr !== 8'h03) begin errs++; $display("FAIL wb_word1: got %h addr %h want 00000031 03", data_line_data[63:32], data_line_addr); end
    is_req_data = 1'b0;
    repeat (2) tick();
    vec++; if (dv_cnt - d0 != 1) begin errs++; $display("FAIL wb_count: got %0d want 1", dv_cnt - d0); end
  endtask

  task automatic test_simultaneous();
    int t0, pc, dc;
    bit ok;
    pc = pv_cnt;
    dc = dv_cnt;
    t0 = cyc;
    is_req_prog = 1'b1;
    req_addr_prog = 18'h00001;
    is_req_data = 1'b1;
    req_addr_data = 18'h00002;
    wait_valid(1'b1, ok);
    vec++; if (!ok || dv_cyc - t0 != 18 || pv_cnt != pc) begin errs++; $display("FAIL sim_data_first: got lat %0d prog %0d want 18 0", dv_cyc - t0, pv_cnt - pc); end
    wait_valid(1'b0, ok);
    vec++; if (!ok || pv_cyc - dv_cyc != 19) begin errs++; $display("FAIL sim_gap: got %0d want 19", pv_cyc - dv_cyc); end
    vec++; if (data_line_addr !== 8'h02 || data_line_data[31:0] !== 32'd32) begin errs++; $display("FAIL sim_data_line: got %h %h want 02 00000020", data_line_addr, data_line_data[31:0]); end
    vec++; if (prog_line_addr !== 8'h01 || prog_line_data[511:480] !== 32'd31) begin errs++; $display("FAIL sim_prog_line: got %h %h want 01 0000001f", prog_line_addr, prog_line_data[511:480]); end
    repeat (45) tick();
    vec++; if (pv_cnt - pc != 1 || dv_cnt - dc != 1) begin errs++; $display("FAIL sim_no_double: got prog %0d data %0d want 1 1", pv_cnt - pc, dv_cnt - dc); end
    is_req_prog = 1'b0;
    is_req_data = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_fill();
    int t0, t1, dc;
    bit ok, bad;
    logic [511:0] exp;
    for (int k = 0; k < 16; k++) exp[32*k +: 32] = 64 + k;
    dc = dv_cnt;
    t0 = cyc;
    is_req_data = 1'b1;
    req_addr_data = 18'h00004;
    repeat (9) tick();
    vec++; if (mem_addr !== 22'h48 || !mem_en) begin errs++; $display("FAIL mid_k8_addr: got %h en %b want 000048 1", mem_addr, mem_en); end
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_line_valid || mem_en || data_line_data !== '0) bad = 1'b1;
    end
    vec++; if (bad) begin errs++; $display("FAIL mid_in_reset: got activity want valid=0 mem_en=0 line=0"); end
    t1 = cyc;
    reset = 1'b0;
    wait_valid(1'b1, ok);
    vec++; if (!ok || dv_cyc - t1 != 18) begin errs++; $display("FAIL mid_restart_latency: got %0d want 18", dv_cyc - t1); end
    vec++; if (data_line_data !== exp || data_line_addr !== 8'h04) begin errs++; $display("FAIL mid_line: got w0=%h addr %h want 00000040 04", data_line_data[31:0], data_line_addr); end
    vec++; if (dv_cnt - dc != 1 || t1 - t0 != 12) begin errs++; $display("FAIL mid_count: got %0d want 1", dv_cnt - dc); end
    is_req_data = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_fifo();
    int p0, n;
    p0 = pop_cnt;
    push(32'h0000_0400, 32'hA1A1A1A1);
    push(32'h0000_0404, 32'hA2A2A2A2);
    push(32'h0000_0408, 32'hA3A3A3A3);
    repeat (15) tick();
    n = pop_t.size();
    vec++; if (pop_cnt - p0 != 3) begin errs++; $display("FAIL fifo_pops: got %0d want 3", pop_cnt - p0); end
    vec++; if (n < 3 || pop_t[n-1] - pop_t[n-2] != 2 || pop_t[n-2] - pop_t[n-3] != 2) begin errs++; $display("FAIL fifo_spacing: got pop spacing off want 2"); end
    vec++; if (pop_empty != 0) begin errs++; $display("FAIL fifo_pop_empty: got %0d want 0", pop_empty); end
    vec++; if (!wb_fifo_empty || wb_pop || mem_en) begin errs++; $display("FAIL fifo_idle: got empty=%b pop=%b en=%b want 1 0 0", wb_fifo_empty, wb_pop, mem_en); end
    vec++; if (mem[12'h100] !== 32'hA1A1A1A1 || mem[12'h101] !== 32'hA2A2A2A2 || mem[12'h102] !== 32'hA3A3A3A3) begin errs++; $display("FAIL fifo_mem: got %h %h %h want a1a1a1a1 a2a2a2a2 a3a3a3a3", mem[12'h100], mem[12'h101], mem[12'h102]); end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_wb_order();
    test_simultaneous();
    test_reset_mid_fill();
    test_fifo();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have port main_clk, in, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, in, 1: reset is asynchronous and active-high.
REQ-003 SHALL have ports is_req_prog / is_req_data, in, 1 each: level line-fill request from the program / data cache.
REQ-004 SHALL have ports req_addr_prog / req_addr_data, in, 18 each: line address; 16 x 32-bit words per line.
REQ-005 SHALL have ports wb_fifo_empty in 1, wb_addr in 32, wb_data in 32, wb_pop out 1: first-word-fall-through write-back FIFO head; wb_pop pops the head.
REQ-006 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 22 (word address), mem_wdata out 32, mem_rdata in 32: word memory, read data valid exactly 1 cycle after mem_en with mem_we=0.
REQ-007 SHALL have ports prog_line_data / data_line_data, out, 512 each, and prog_line_addr / data_line_addr, out, 8 each.
REQ-008 SHALL have ports prog_line_valid / data_line_valid, out, 1 each: one-cycle strobe; it is the fill-FIFO write enable on the cache side.

Function
REQ-009 SHALL implement FSM states IDLE, WB, FILL and DELIVER.
REQ-010 IDLE: if wb_fifo_empty=0, SHALL go to WB; else if data is eligible, FILL for data; else if prog is eligible, FILL for prog; else stay.
REQ-011 Eligibility SHALL be is_req_x=1 and served_x=0; served_x is set in DELIVER for source x and cleared on any cycle with is_req_x=0.
REQ-012 Write-backs SHALL always win over fills so that a fill observes every earlier write.
REQ-013 WB: one cycle with mem_en=1, mem_we=1, mem_addr=wb_addr[23:2], mem_wdata=wb_data, wb_pop=1; then IDLE.
REQ-014 On accepting a fill in IDLE, the FSM SHALL latch source and req_addr; a later change of req_addr SHALL NOT affect the fill in progress.
REQ-015 FILL SHALL last 17 cycles, using counter k=0..16.
REQ-016 FILL for k<16: SHALL drive mem_en=1, mem_we=0, mem_addr={latched_addr,k[3:0]}.
REQ-017 FILL for k>=1: SHALL capture mem_rdata into line bits [32(k-1)+31 : 32(k-1)].
REQ-018 DELIVER, one cycle: SHALL drive the selected x_line_data with the assembled line, x_line_addr=latched_addr[7:0], and x_line_valid=1; then IDLE.
REQ-019 Latency: accept at cycle T; x_line_valid SHALL be high at T+18, with no write-back pending.
REQ-020 x_line_data and x_line_addr SHALL hold their value until the next delivery to the same source; the other source's outputs SHALL be unchanged.
REQ-021 Outside WB and FILL, mem_en, mem_we and wb_pop SHALL be 0.
REQ-022 wb_pop SHALL never be asserted while wb_fifo_empty=1.
REQ-023 A fill in progress SHALL NOT be pre-empted; write-backs arriving during FILL SHALL wait until the next IDLE.
REQ-024 Simultaneous eligible prog and data requests: data SHALL be served first, then prog on the next IDLE with no write-back pending.

Reset
REQ-025 While reset=1: state=IDLE, k=0, served_prog=served_data=0, all *_line_valid=0, mem_en=mem_we=wb_pop=0, line_data=0, line_addr=0.
REQ-026 Reset during FILL SHALL discard the partial line, and no delivery SHALL follow.
REQ-027 Reset during WB SHALL leave memory state undefined for that word only.

Structure
REQ-028 Package main_mem_pkg SHALL hold LINE_WORDS=16, LINE_BITS=512, REQ_ADDR_W=18, MEM_ADDR_W=22, and the FSM state enum.
REQ-029 Word counter, line assembly and address generation SHALL live in sub-module line_fill_engine (start, base_addr, mem_rdata in; done, line out).
REQ-030 Top SHALL contain arbitration, the served flags and the WB path.

Verification
REQ-031 Single prog fill: memory word n = n; is_req_prog=1, req_addr_prog=18'h00003, starting at T -> prog_line_valid at T+18; prog_line_addr=8'h03; word k = 48+k.
REQ-032 Write-then-fill ordering: FIFO holds (addr 32'h0000_00C0, data 32'hDEADBEEF); data fill of line 3 requested in the same cycle -> WB first; delivered word 0 = 32'hDEADBEEF.
REQ-033 Simultaneous requests: prog line 1 and data line 2 both requested -> data_line_valid first, prog_line_valid exactly 19 cycles later; no double delivery while is_req stays high.
REQ-034 Reset mid-fill: assert reset at FILL k=8, release, keep is_req_data=1 -> no valid during reset; full 18-cycle fill restarts; correct line delivered.
REQ-035 FIFO boundary: 3 write-back entries and an empty FIFO afterwards -> exactly 3 wb_pop pulses, spaced 2 cycles apart, and no pop while empty.
